// File: rtl/clock_time_ctrl.sv
// Time-of-day controller: hours:minutes counter with a mode/increment set-time sequence.
// Optional 12-hour display conversion is enabled by defining CLOCK_TIME_CTRL_H12_EN.
module clock_time_ctrl #(
   parameter int unsigned REPEAT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       min_tick,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [5:0] minutes,
   output logic [4:0] hours,
   output logic [1:0] state,
   output logic       day_tick,
   output logic       pm
);

   typedef enum logic [1:0] {
      StRun  = 2'b00,
      StSetH = 2'b01,
      StSetM = 2'b10,
      StBad  = 2'b11
   } state_e;

   localparam logic [7:0] RepLast = 8'(REPEAT - 1);

   state_e     state_q, state_d;
   logic [5:0] min_q, min_d;
   logic [4:0] hr_q, hr_d;
   logic       day_q, day_d;
   logic       mode_q, inc_q;
   logic [7:0] hold_q, hold_d;
   logic       armed_q, armed_d;
   logic       mode_edge, inc_edge, set_mode, rep_ev, inc_ev;

   assign mode_edge = mode_btn & ~mode_q;
   assign inc_edge  = inc_btn & ~inc_q;
   assign set_mode  = (state_q == StSetH) || (state_q == StSetM);

   // Auto-repeat only runs after a genuine press seen in a set state, so a button
   // held across reset or a mode change must be released and pressed again.
   always_comb begin
      hold_d  = hold_q;
      armed_d = armed_q;
      rep_ev  = 1'b0;
      if (!inc_btn || !set_mode || mode_edge) begin
         hold_d  = 8'd0;
         armed_d = 1'b0;
      end else if (inc_edge) begin
         hold_d  = 8'd0;
         armed_d = 1'b1;
      end else if (armed_q) begin
         if (hold_q == RepLast) begin
            hold_d = 8'd0;
            rep_ev = 1'b1;
         end else begin
            hold_d = hold_q + 8'd1;
         end
      end
   end

   assign inc_ev = set_mode & ~mode_edge & (inc_edge | rep_ev);

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      hr_d    = hr_q;
      day_d   = 1'b0;
      case (state_q)
         StRun: begin
            if (min_tick) begin
               if (min_q == 6'd59) begin
                  min_d = 6'd0;
                  if (hr_q == 5'd23) begin
                     hr_d  = 5'd0;
                     day_d = 1'b1;
                  end else begin
                     hr_d = hr_q + 5'd1;
                  end
               end else begin
                  min_d = min_q + 6'd1;
               end
            end
            if (mode_edge) state_d = StSetH;
         end
         StSetH: begin
            if (mode_edge) begin
               state_d = StSetM;
            end else if (inc_ev) begin
               hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end
         end
         StSetM: begin
            if (mode_edge) begin
               state_d = StRun;
            end else if (inc_ev) begin
               min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StRun;
         min_q   <= 6'd0;
         hr_q    <= 5'd0;
         day_q   <= 1'b0;
         mode_q  <= 1'b1;
         inc_q   <= 1'b1;
         hold_q  <= 8'd0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         hr_q    <= hr_d;
         day_q   <= day_d;
         mode_q  <= mode_btn;
         inc_q   <= inc_btn;
         hold_q  <= hold_d;
         armed_q <= armed_d;
      end
   end

   assign minutes  = min_q;
   assign state    = state_q;
   assign day_tick = day_q;

`ifdef CLOCK_TIME_CTRL_H12_EN
   always_comb begin
      if (hr_q == 5'd0) begin
         hours = 5'd12;
      end else if (hr_q > 5'd12) begin
         hours = hr_q - 5'd12;
      end else begin
         hours = hr_q;
      end
   end
   assign pm = (hr_q >= 5'd12);
`else
   assign hours = hr_q;
   assign pm    = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: expectations are queued as stimulus is driven
// and popped against the registered outputs one cycle later.
module tb_clock_time_ctrl;

   logic       clk;
   logic       rst_n;
   logic       min_tick;
   logic       mode_btn;
   logic       inc_btn;
   logic [5:0] minutes;
   logic [4:0] hours;
   logic [1:0] state;
   logic       day_tick;
   logic       pm;

   int checks = 0;
   int errors = 0;
   int eh, em;

   typedef struct {
      string       tag;
      logic [14:0] v;
   } exp_t;

   exp_t sb[$];

   clock_time_ctrl #(
      .REPEAT(8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .min_tick (min_tick),
      .mode_btn (mode_btn),
      .inc_btn  (inc_btn),
      .minutes  (minutes),
      .hours    (hours),
      .state    (state),
      .day_tick (day_tick),
      .pm       (pm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed {minutes, hours, state, day_tick, pm} for a given internal time.
   function automatic logic [14:0] pack_exp(int m, int h, logic [1:0] s, logic d);
      logic [4:0] hd;
      logic       p;
`ifdef CLOCK_TIME_CTRL_H12_EN
      hd = 5'((h == 0) ? 12 : ((h > 12) ? h - 12 : h));
      p  = (h >= 12);
`else
      hd = h[4:0];
      p  = 1'b0;
`endif
      return {m[5:0], hd, s, d, p};
   endfunction

   function automatic logic [14:0] obs();
      return {minutes, hours, state, day_tick, pm};
   endfunction

   task automatic push_exp(string tag, int m, int h, logic [1:0] s, logic d);
      exp_t e;
      e.tag = tag;
      e.v   = pack_exp(m, h, s, d);
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; min_tick = 1'b0;
      step(); step();
      push_exp("reset", 0, 0, 2'b00, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      rst_n = 1'b1;
      step();
      push_exp("reset_release", 0, 0, 2'b00, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
   endtask

   task automatic test_run_count();
      exp_t e;
      for (int i = 1; i <= 60; i++) begin
         min_tick = 1'b1;
         step();
         push_exp("run_tick", i % 60, i / 60, 2'b00, 1'b0);
         e = sb.pop_front(); checks++;
         if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
         min_tick = 1'b0;
         step();
      end
      em = 0; eh = 1;
   endtask

   task automatic test_mode_seq();
      exp_t e;
      for (int i = 1; i <= 3; i++) begin
         mode_btn = 1'b1;
         step();
         push_exp("mode_seq", em, eh, 2'(i % 3), 1'b0);
         e = sb.pop_front(); checks++;
         if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
         mode_btn = 1'b0;
         step();
      end
   endtask

   task automatic test_set_wrap();
      exp_t e;
      mode_btn = 1'b1; step(); mode_btn = 1'b0; step();
      // 46 presses from 1 passes 12, 13 and the 23->0 wrap, ending at 23
      for (int i = 0; i < 46; i++) begin
         inc_btn = 1'b1;
         step();
         eh = (eh + 1) % 24;
         push_exp("set_h_inc", em, eh, 2'b01, 1'b0);
         e = sb.pop_front(); checks++;
         if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
         inc_btn = 1'b0;
         step();
      end
      mode_btn = 1'b1; step();
      push_exp("to_set_m", em, eh, 2'b10, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      mode_btn = 1'b0; step();
      for (int i = 0; i < 119; i++) begin
         inc_btn = 1'b1;
         step();
         em = (em + 1) % 60;
         push_exp((i == 59) ? "set_m_wrap" : "set_m_inc", em, 23, 2'b10, 1'b0);
         e = sb.pop_front(); checks++;
         if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
         inc_btn = 1'b0;
         step();
      end
      mode_btn = 1'b1; step(); mode_btn = 1'b0; step();
      min_tick = 1'b1; step();
      push_exp("day_roll", 0, 0, 2'b00, 1'b1);
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      min_tick = 1'b0; step();
      push_exp("day_tick_once", 0, 0, 2'b00, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      em = 0; eh = 0;
   endtask

   task automatic test_hold();
      exp_t e;
      mode_btn = 1'b1; step(); mode_btn = 1'b0; step();
      for (int i = 0; i < 5; i++) begin
         inc_btn = 1'b1; step(); inc_btn = 1'b0; step();
      end
      eh = 5;
      inc_btn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (k % 8 == 0) eh = eh + 1;
         push_exp("hold_repeat", em, eh, 2'b01, 1'b0);
         e = sb.pop_front(); checks++;
         if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      end
      inc_btn = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         push_exp("hold_release", em, 8, 2'b01, 1'b0);
         e = sb.pop_front(); checks++;
         if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 19; i++) begin
         inc_btn = 1'b1; step(); inc_btn = 1'b0; step();
      end
      mode_btn = 1'b1; inc_btn = 1'b1; step();
      push_exp("mode_inc_same", 0, 3, 2'b10, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      mode_btn = 1'b0; inc_btn = 1'b0; step();
      for (int i = 0; i < 10; i++) begin
         min_tick = 1'b1; step();
         push_exp("set_m_tick_drop", 0, 3, 2'b10, 1'b0);
         e = sb.pop_front(); checks++;
         if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
         min_tick = 1'b0; step();
      end
      mode_btn = 1'b1; step(); mode_btn = 1'b0; step();
      min_tick = 1'b1; step();
      push_exp("run_after_set", 1, 3, 2'b00, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      min_tick = 1'b0; step();
      mode_btn = 1'b1; min_tick = 1'b1; step();
      push_exp("mode_tick_same", 2, 3, 2'b01, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      mode_btn = 1'b0; min_tick = 1'b0; step();
   endtask

   task automatic test_reset_hold();
      exp_t e;
      inc_btn = 1'b1; step();
      push_exp("pre_reset_inc", 2, 4, 2'b01, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      step(); step(); step();
      rst_n = 1'b0; step();
      push_exp("mid_hold_reset", 0, 0, 2'b00, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         push_exp("run_inc_ignored", 0, 0, 2'b00, 1'b0);
         e = sb.pop_front(); checks++;
         if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      end
      mode_btn = 1'b1; step(); mode_btn = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         push_exp("held_no_repeat", 0, 0, 2'b01, 1'b0);
         e = sb.pop_front(); checks++;
         if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      end
      inc_btn = 1'b0; step();
      inc_btn = 1'b1; step();
      push_exp("repress_inc", 0, 1, 2'b01, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h required %h {min,hr,st,dt,pm}", e.tag, obs(), e.v); end
      inc_btn = 1'b0; step();
   endtask

   initial begin
      test_reset();
      test_run_count();
      test_mode_seq();
      test_set_wrap();
      test_hold();
      test_back_to_back();
      test_reset_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Time-of-day controller for the digital clock. It consumes the one-cycle minute tick derived from the minute clock generator and keeps the hours:minutes count. It sequences the user "set time" interaction from two push-buttons (mode, increment), including hold-to-auto-repeat. It sits between the minute clock source and the display/alarm blocks.

## Interface
Parameters:
- REPEAT, default 8: cycles `inc_btn` must stay high for each auto-repeat increment (legal range 2..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- min_tick  in  1  one-cycle pulse, once per minute.
- mode_btn  in  1  mode button level, already synchronized/debounced.
- inc_btn  in  1  increment button level, already synchronized/debounced.
- minutes  out  6  current minutes, binary 0..59.
- hours  out  5  current hours, binary 0..23 (see Configuration).
- state  out  2  mode: 2'b00 RUN, 2'b01 SET_H, 2'b10 SET_M.
- day_tick  out  1  one-cycle pulse on 23:59 -> 00:00 rollover.
- pm  out  1  PM flag (H12_EN only, else constant 0).

## Operation
- Edge detect: `mode_edge = mode_btn & ~mode_q`; `inc_edge = inc_btn & ~inc_q`.
  - `mode_q` and `inc_q` reset to 1, so a button already held at reset release produces no edge.
- FSM: RUN -> SET_H -> SET_M -> RUN, advancing one step per `mode_edge`. State 2'b11 is unreachable; if ever entered, go to RUN next cycle.
- RUN, on `min_tick`:
  - minutes+1.
  - If minutes=59: minutes=0 and hours+1.
  - If hours=23 and minutes=59: both go to 0 and `day_tick`=1 for that cycle.
- SET_H / SET_M:
  - `min_tick` is dropped, not queued.
  - Each increment event adds 1 to the selected field only, with independent wrap: hours 23->0, minutes 59->0.
  - No carry between fields and no `day_tick`.
- Increment event:
  - `inc_edge`.
  - Or auto-repeat: an 8-bit hold counter clears on `inc_edge` and counts while `inc_btn` stays high. Each time it reaches REPEAT-1, an event fires and the counter returns to 0.
  - The counter clears whenever `inc_btn`=0, in RUN, or on `mode_edge`.
- Simultaneous events:
  - `mode_edge` with `inc_edge` or a repeat event: the state advances and the increment is discarded.
  - `mode_edge` in RUN with `min_tick`: the tick is applied and the state advances the same cycle.
- `inc_btn` in RUN has no effect.

## Timing
- Reset values (cycle after `rst_n`=0 is sampled): minutes=0, hours=0, state=RUN, day_tick=0, pm=0, hold counter=0.
- Reset mid-operation, including mid-hold: all of the above; a still-held button needs release and re-press.
- Latency: input sampled at edge N; `minutes`, `hours`, `state` and `day_tick` reflect it after edge N (registered, 1 cycle).
- `pm` and 12h hours are combinational from the internal hour register, so they add no latency.
- `day_tick` is high for exactly one cycle and never in two consecutive cycles.
- Hold timing: press at edge P gives an event at P. With `inc_btn` held, further events follow at P+REPEAT, P+2·REPEAT, and so on.

## Configuration
- Macro `CLOCK_TIME_CTRL_H12_EN`.
- Defined:
  - Internal hours remain 0..23.
  - `hours` output shows 12 for internal 0 and 12, internal-12 for 13..23, and unchanged for 1..11.
  - `pm`=1 for internal 12..23.
- Undefined:
  - `hours` equals the internal value (0..23).
  - `pm` is tied to 0.
  - No conversion logic is synthesized.
- FSM, counters and `day_tick` are identical in both builds.

## Test plan
- Reset, then 60 `min_tick` pulses in RUN -> 01:00 and no `day_tick`. Set 23:59, one `min_tick` -> 00:00 with `day_tick`=1 for exactly 1 cycle.
- Three `mode_btn` presses -> `state` 01, 10, 00. In SET_M at 59, one `inc_btn` press -> minutes=0 and hours unchanged.
- SET_H at hours=5, REPEAT=8, hold `inc_btn` 20 cycles -> events at cycles 0, 8, 16 -> hours=8. Release -> no further change.
- SET_M, pulse `min_tick` 10 times -> minutes unchanged. Return to RUN -> next `min_tick` increments by exactly 1.
- Same-cycle `mode_edge` and `inc_edge` in SET_H at hours=3 -> state=SET_M and hours=3. Hold `inc_btn` through `rst_n`=0 -> all outputs reset and no increment until re-press.
- H12_EN build: hours internal 0, 12, 13 -> outputs 12/pm=0, 12/pm=1, 1/pm=1. Non-H12 build -> 0, 12, 13 with pm=0.
